// File: rtl/shift_arbiter_pkg.sv
// Shared ALU definitions for the shifter blocks: op codes, arbiter FSM states,
// and the illegal-op decode.
package shift_arbiter_pkg;

  localparam logic [2:0] OP_LSL = 3'b000;
  localparam logic [2:0] OP_LSR = 3'b001;
  localparam logic [2:0] OP_ASR = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  // Codes from here upward have no shift-unit meaning.
  localparam logic [2:0] OP_ILLEGAL_MIN = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  function automatic logic op_illegal(input logic [2:0] op);
    return (op >= OP_ILLEGAL_MIN);
  endfunction

endpackage

// File: rtl/shift_arbiter_rr_arb2.sv
// Two-way round-robin grant; the pointer remembers the last requester granted
// and advances only when a grant is actually taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last;

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = last ? 2'b01 : 2'b10;
  end

  // Reset value 1 makes requester 0 the first winner under contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  last <= 1'b1;
    else if (advance && |req) last <= grant[1];
  end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one external fixed-latency shift unit between two requesters with
// round-robin arbitration and a per-requester valid/ready response channel.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int SHW    = 4,
  parameter int SH_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  input  logic [SHW-1:0]   req_amt0,
  input  logic [SHW-1:0]   req_amt1,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  output logic [WIDTH-1:0] sh_inp,
  output logic [SHW-1:0]   sh_shift_value,
  output logic [2:0]       sh_op,
  input  logic [WIDTH-1:0] sh_out,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err
);

  localparam int CW = (SH_LAT < 2) ? 1 : $clog2(SH_LAT);
  localparam logic [CW-1:0] CNT_LAST = CW'(SH_LAT - 1);

  state_e           state, state_nxt;
  logic [1:0]       grant;
  logic             gnt_id;
  logic [WIDTH-1:0] lat_data;
  logic [SHW-1:0]   lat_amt;
  logic [2:0]       lat_op;
  logic [CW-1:0]    cnt;
  logic             lat_illegal;

  assign lat_illegal = op_illegal(lat_op);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (state == IDLE),
    .grant   (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    req_ready      = '0;
    rsp_valid      = '0;
    sh_inp         = '0;
    sh_shift_value = '0;
    sh_op          = '0;
    case (state)
      IDLE: begin
        // Gated by rst so the combinational handshake is quiet while in reset.
        if (|req_valid && !rst) begin
          req_ready = grant;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (lat_illegal) begin
          state_nxt = RESP;
        end else begin
          sh_inp         = lat_data;
          sh_shift_value = lat_amt;
          sh_op          = lat_op;
          state_nxt      = WAIT;
        end
      end
      WAIT: begin
        sh_inp         = lat_data;
        sh_shift_value = lat_amt;
        sh_op          = lat_op;
        if (cnt == CNT_LAST) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid[gnt_id] = 1'b1;
        if (rsp_ready[gnt_id]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_id   <= 1'b0;
      lat_data <= '0;
      lat_amt  <= '0;
      lat_op   <= '0;
      cnt      <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            gnt_id   <= grant[1];
            lat_data <= grant[1] ? req_data1 : req_data0;
            lat_amt  <= grant[1] ? req_amt1  : req_amt0;
            lat_op   <= grant[1] ? req_op1   : req_op0;
            cnt      <= '0;
          end
        end
        ISSUE: begin
          if (lat_illegal) begin
            rsp_data <= lat_data;
            rsp_err  <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == CNT_LAST) rsp_data <= sh_out;
          else                 cnt      <= cnt + 1'b1;
        end
        RESP: begin
          if (rsp_ready[gnt_id]) rsp_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with a registered (1-cycle) shift unit model.
module tb_shift_arbiter;
  import shift_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [15:0] req_data0 = '0, req_data1 = '0;
  logic [3:0]  req_amt0 = '0, req_amt1 = '0;
  logic [2:0]  req_op0 = '0, req_op1 = '0;
  logic [15:0] sh_inp;
  logic [3:0]  sh_shift_value;
  logic [2:0]  sh_op;
  logic [15:0] sh_out = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = '0;
  logic [15:0] rsp_data;
  logic        rsp_err;

  int checks = 0;
  int failures = 0;

  shift_arbiter #(.WIDTH(16), .SHW(4), .SH_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data0(req_data0), .req_data1(req_data1),
    .req_amt0(req_amt0), .req_amt1(req_amt1),
    .req_op0(req_op0), .req_op1(req_op1),
    .sh_inp(sh_inp), .sh_shift_value(sh_shift_value), .sh_op(sh_op),
    .sh_out(sh_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] shift_model(input logic [15:0] x, input logic [3:0] a,
                                              input logic [2:0] op);
    logic [4:0] inv;
    inv = 5'd16 - {1'b0, a};
    case (op)
      3'b000:  return x << a;
      3'b001:  return x >> a;
      3'b010:  return 16'($signed(x) >>> a);
      3'b011:  return (x << a) | (x >> inv);
      3'b100:  return (x >> a) | (x << inv);
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) sh_out <= shift_model(sh_inp, sh_shift_value, sh_op);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in IDLE with requests driven; ends back in IDLE after acceptance.
  task automatic run_op(input string tag, input logic [1:0] exp_g, input logic [1:0] valid_after,
                        input logic [15:0] e_inp, input logic [3:0] e_amt, input logic [2:0] e_op,
                        input logic [15:0] e_data, input logic e_err, input int bp);
    #1;
    check({tag, ".grant"}, 32'(req_ready), 32'(exp_g));
    step();
    req_valid = valid_after;
    check({tag, ".issue_rdy"}, 32'(req_ready), 32'(0));
    check({tag, ".sh_inp"}, 32'(sh_inp), 32'(e_inp));
    check({tag, ".sh_amt"}, 32'(sh_shift_value), 32'(e_amt));
    check({tag, ".sh_op"}, 32'(sh_op), 32'(e_op));
    if (!e_err) begin
      step();
      check({tag, ".wait_hold"}, 32'(sh_inp), 32'(e_inp));
      check({tag, ".wait_rspv"}, 32'(rsp_valid), 32'(0));
    end
    step();
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(exp_g));
    check({tag, ".rsp_data"}, 32'(rsp_data), 32'(e_data));
    check({tag, ".rsp_err"}, 32'(rsp_err), 32'(e_err));
    check({tag, ".sh_idle"}, 32'(sh_inp), 32'(0));
    rsp_ready = ~exp_g;
    for (int i = 0; i < bp; i++) begin
      step();
      check({tag, ".bp_valid"}, 32'(rsp_valid), 32'(exp_g));
      check({tag, ".bp_data"}, 32'(rsp_data), 32'(e_data));
      check({tag, ".bp_err"}, 32'(rsp_err), 32'(e_err));
      check({tag, ".bp_nogrant"}, 32'(req_ready), 32'(0));
    end
    rsp_ready = exp_g;
    step();
    rsp_ready = '0;
    check({tag, ".acc_valid"}, 32'(rsp_valid), 32'(0));
    check({tag, ".acc_err"}, 32'(rsp_err), 32'(0));
  endtask

  initial begin
    // Reset with both requesters already asking.
    req_valid = 2'b11;
    req_data0 = 16'h0001; req_amt0 = 4'd1; req_op0 = OP_ROL;
    req_data1 = 16'h8001; req_amt1 = 4'd1; req_op1 = OP_LSR;
    step();
    check("rst.req_ready", 32'(req_ready), 32'(0));
    check("rst.rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst.rsp_data", 32'(rsp_data), 32'(0));
    check("rst.rsp_err", 32'(rsp_err), 32'(0));
    check("rst.sh_inp", 32'(sh_inp), 32'(0));
    check("rst.sh_op", 32'(sh_op), 32'(0));
    step();
    rst = 1'b0;

    // Contention: grants alternate 0,1,0,1.
    run_op("cont0", 2'b01, 2'b11, 16'h0001, 4'd1, OP_ROL, 16'h0002, 1'b0, 0);
    run_op("cont1", 2'b10, 2'b11, 16'h8001, 4'd1, OP_LSR, 16'h4000, 1'b0, 0);
    run_op("cont2", 2'b01, 2'b11, 16'h0001, 4'd1, OP_ROL, 16'h0002, 1'b0, 0);
    run_op("cont3", 2'b10, 2'b00, 16'h8001, 4'd1, OP_LSR, 16'h4000, 1'b0, 0);

    req_valid = 2'b01; req_data0 = 16'h000B; req_amt0 = 4'd4; req_op0 = OP_ROL;
    run_op("single", 2'b01, 2'b00, 16'h000B, 4'd4, OP_ROL, 16'h00B0, 1'b0, 0);

    // Backpressure with requester 0 waiting; it then withdraws before any grant.
    req_valid = 2'b10; req_data1 = 16'h800B; req_amt1 = 4'd4; req_op1 = OP_ROL;
    run_op("bp", 2'b10, 2'b01, 16'h800B, 4'd4, OP_ROL, 16'h00B8, 1'b0, 5);
    req_valid = 2'b00;
    step();
    check("drop.req_ready", 32'(req_ready), 32'(0));
    check("drop.sh_inp", 32'(sh_inp), 32'(0));

    req_valid = 2'b10; req_data1 = 16'h1234; req_amt1 = 4'd3; req_op1 = 3'b110;
    run_op("illegal", 2'b10, 2'b00, 16'h0000, 4'd0, 3'b000, 16'h1234, 1'b1, 0);

    req_valid = 2'b01; req_data0 = 16'h8000; req_amt0 = 4'd3; req_op0 = OP_ASR;
    run_op("asr", 2'b01, 2'b00, 16'h8000, 4'd3, OP_ASR, 16'hF000, 1'b0, 0);

    req_valid = 2'b10; req_data1 = 16'h00FF; req_amt1 = 4'd8; req_op1 = OP_LSL;
    run_op("lsl", 2'b10, 2'b00, 16'h00FF, 4'd8, OP_LSL, 16'hFF00, 1'b0, 0);

    req_valid = 2'b01; req_data0 = 16'hFFFF; req_amt0 = 4'd0; req_op0 = OP_ROR;
    run_op("amt0", 2'b01, 2'b00, 16'hFFFF, 4'd0, OP_ROR, 16'hFFFF, 1'b0, 0);

    // Reset while waiting on the shift unit.
    req_valid = 2'b01; req_data0 = 16'h1111; req_amt0 = 4'd1; req_op0 = OP_LSL;
    #1;
    check("mid.grant", 32'(req_ready), 32'(2'b01));
    step();
    req_valid = 2'b00;
    step();
    check("mid.wait_sh", 32'(sh_inp), 32'(16'h1111));
    rst = 1'b1;
    req_valid = 2'b11;
    #1;
    check("mid.sh_inp", 32'(sh_inp), 32'(0));
    check("mid.sh_amt", 32'(sh_shift_value), 32'(0));
    check("mid.rsp_valid", 32'(rsp_valid), 32'(0));
    check("mid.rsp_data", 32'(rsp_data), 32'(0));
    check("mid.req_ready", 32'(req_ready), 32'(0));
    step();
    check("mid.no_rsp", 32'(rsp_valid), 32'(0));
    rst = 1'b0;
    req_data0 = 16'h0003; req_amt0 = 4'd2; req_op0 = OP_LSL;
    req_data1 = 16'h5555; req_amt1 = 4'd1; req_op1 = OP_LSR;
    run_op("post_rst", 2'b01, 2'b00, 16'h0003, 4'd2, OP_LSL, 16'h000C, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #100000;
    $display("FAIL timeout got=stuck exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter WIDTH, 16, operand/result width in bits.
REQ-002 Parameter SHW, 4, shift-amount width in bits; SHW SHALL equal log2(WIDTH).
REQ-003 Parameter SH_LAT, 1, fixed latency in clk cycles of the external shift unit.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-007 req_ready  output  2  per-requester request accepted this cycle.
REQ-008 req_data0, req_data1  input  WIDTH  operand from requester 0 or 1.
REQ-009 req_amt0, req_amt1  input  SHW  shift amount from requester 0 or 1.
REQ-010 req_op0, req_op1  input  3  operation code: 000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR; 101-111 illegal.
REQ-011 sh_inp  output  WIDTH  operand driven to the shared shift unit.
REQ-012 sh_shift_value  output  SHW  amount driven to the shared shift unit.
REQ-013 sh_op  output  3  operation driven to the shared shift unit.
REQ-014 sh_out  input  WIDTH  shift-unit result, valid SH_LAT cycles after issue.
REQ-015 rsp_valid  output  2  per-requester response valid.
REQ-016 rsp_ready  input  2  per-requester response accepted.
REQ-017 rsp_data  output  WIDTH  response result, shared by both requesters.
REQ-018 rsp_err  output  1  response carries an illegal-op error.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-020 IDLE: if any req_valid bit is set, grant one requester, assert req_ready[g] for that cycle only, latch data/amt/op, and go to ISSUE; otherwise stay in IDLE.
REQ-021 Arbitration SHALL be round-robin: when both requesters are valid, grant the requester that is not the last one granted; after reset, requester 0 wins.
REQ-022 The priority pointer SHALL update only on a grant.
REQ-023 req_ready SHALL be 0 in every state except the IDLE grant cycle, and SHALL never assert for both bits at once.
REQ-024 ISSUE, legal op: drive latched operands on sh_inp/sh_shift_value/sh_op for one cycle, then go to WAIT.
REQ-025 sh_* outputs SHALL hold their latched values from ISSUE until the result is captured; outside that window they SHALL be 0.
REQ-026 WAIT: count SH_LAT cycles, capture sh_out into rsp_data on the last count, then go to RESP; issue-to-capture latency SHALL be exactly SH_LAT cycles.
REQ-027 ISSUE, illegal op: skip the shift unit, load rsp_data with the unmodified operand, set rsp_err=1, and go directly to RESP.
REQ-028 RESP: assert rsp_valid[g] only and hold rsp_data/rsp_err stable until rsp_ready[g]=1; on that cycle clear rsp_valid and rsp_err and return to IDLE.
REQ-029 Minimum request-to-request spacing SHALL be 3+SH_LAT cycles; there is no back-to-back issue.
REQ-030 rsp_ready on the non-granted bit, or outside RESP, SHALL be ignored.
REQ-031 A shift amount of 0 SHALL be passed through unmodified; the arbiter performs no arithmetic on operands.
REQ-032 A req_valid deasserted before grant SHALL be dropped without side effects.

Reset
REQ-033 On rst=1, asynchronously: state=IDLE, priority pointer=requester 1 last, and req_ready, rsp_valid, rsp_data, rsp_err, sh_inp, sh_shift_value, sh_op, and the latency counter all 0.
REQ-034 Reset mid-operation SHALL abandon the in-flight request with no response; the first post-reset grant goes to requester 0.

Structure
REQ-035 The op-code constants, FSM state encoding, and the illegal-op decode range SHALL live in the shared ALU package used by the shifter blocks.
REQ-036 One sub-module, rr_arb2 (2-way round-robin grant with pointer), is natural.
REQ-037 The shift unit is external; no shift logic SHALL be inside shift_arbiter.

Verification
REQ-038 Scenario, single request: req0 data 0x000B, amt 4, ROL, with a registered ROL shifter -> rsp_valid[0] 3 cycles after grant, rsp_data 0x00B0, rsp_err 0.
REQ-039 Scenario, contention: req0 and req1 both valid from reset -> grant order 0,1,0,1 across four ops; req_ready never 2'b11.
REQ-040 Scenario, backpressure: rsp_ready[1] held low 5 cycles for req1 data 0x800B, amt 4, ROL -> rsp_data stays 0x00B8 and rsp_valid[1] stays high until accepted; no new grant meanwhile.
REQ-041 Scenario, illegal op: req1 op 110, data 0x1234 -> RESP 2 cycles after grant with rsp_data 0x1234, rsp_err 1, sh_* remaining 0.
REQ-042 Scenario, mid-operation reset: assert rst during WAIT -> all outputs 0 immediately, no response; the next contended grant goes to requester 0.
REQ-043 Scenario, amount 0: req0 data 0xFFFF, amt 0, ROR -> rsp_data 0xFFFF; sh_shift_value observed as 0.
